// File: rtl/maze_tft_pkg.sv
// Shared constants for the maze TFT path: panel command bytes and the
// arbiter FSM state encoding.
package maze_tft_pkg;

    // Panel command bytes (column/page address set, memory write)
    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] PASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    // Arbiter state encoding
    typedef logic [1:0] arb_state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/tft_arbiter_rr_pick.sv
// rr_pick: round-robin winner selection. The search starts at the requester
// after last and wraps, so the previous owner is considered last.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win
);

    // Scan upward from last+1 with wrap; first raised request wins
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_arbiter.sv
// tft_arbiter: shares one TFT byte serialiser between NUM_REQ requesters.
// IDLE -> GRANT on any request (round-robin), GRANT -> DRAIN when the owner
// drops req, DRAIN -> IDLE once the serialiser is no longer busy.
// Optional idle-grant watchdog: define TFT_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among eligible requests
//   GRANT | owner's strobe/dc/data passed straight to the serialiser
//   DRAIN | owner released; wait for serialiser to go idle
module tft_arbiter
    import maze_tft_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_transmit,
    input  logic [NUM_REQ-1:0]     req_dc,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     req_busy,
    input  logic                   tft_busy,
    output logic                   tft_transmit,
    output logic                   tft_dc,
    output logic [7:0]             tft_data,
    output logic                   timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        last_grant;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   pick;
    logic [IW-1:0]        pick_idx;
    logic                 wd_fire;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .req  (eligible),
        .last (last_grant),
        .win  (pick)
    );

`ifdef TFT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]      wd_cnt;
    logic [NUM_REQ-1:0] mask;
    logic               wd_silent;

    // Owner holds the link but is neither sending nor waiting on the serialiser
    assign wd_silent = (state == ST_GRANT) && !tft_busy && !req_transmit[gidx];
    // A normal release (req low) takes priority over a watchdog revoke
    assign wd_fire   = wd_silent && req[gidx] && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign eligible  = req & ~mask;

    // Watchdog counter, timeout pulse, and per-requester lockout until req drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
            mask    <= '0;
        end else begin
            timeout <= wd_fire;
            mask    <= (mask & req) | (wd_fire ? grant : '0);
            if (wd_silent && !wd_fire) wd_cnt <= wd_cnt + CW'(1);
            else                       wd_cnt <= '0;
        end
    end
`else
    assign wd_fire  = 1'b0;
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    // One-hot winner to index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // Arbitration FSM with registered grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req[gidx] || wd_fire) begin
                        grant <= '0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!tft_busy) begin
                        last_grant <= gidx;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Serialiser mux: only the owner's signals pass, and only while in GRANT
    always_comb begin
        tft_transmit = 1'b0;
        tft_dc       = 1'b0;
        tft_data     = 8'h00;
        if (state == ST_GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    tft_transmit = req_transmit[i];
                    tft_dc       = req_dc[i];
                    tft_data     = req_data[8*i +: 8];
                end
            end
        end
    end

    // Non-owners always see the link as busy
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_busy[i] = grant[i] ? tft_busy : 1'b1;
        end
    end

endmodule

// File: tb/tb_tft_arbiter.sv
// Bench for tft_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=8). Expected grants come
// from a round-robin rule over the request vector and the previous owner.
module tb_tft_arbiter;
    import maze_tft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  req_transmit = '0;
    logic [2:0]  req_dc = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  grant;
    logic [2:0]  req_busy;
    logic        tft_busy = 1'b0;
    logic        tft_transmit;
    logic        tft_dc;
    logic [7:0]  tft_data;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = 2;

    tft_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_transmit(req_transmit),
        .req_dc(req_dc), .req_data(req_data), .grant(grant), .req_busy(req_busy),
        .tft_busy(tft_busy), .tft_transmit(tft_transmit), .tft_dc(tft_dc),
        .tft_data(tft_data), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int rr_next(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, reporting how many sampled cycles had none
    task automatic wait_grant(input string name, output int zeros);
        zeros = 0;
        for (int g = 0; g < 20 && grant == 3'b000; g++) begin
            zeros++;
            cyc();
        end
        n_checks++;
        if (grant == 3'b000) begin
            n_fail++;
            $display("FAIL %s: no grant within bound, grant=%b", name, grant);
        end
    endtask

    task automatic idle_all();
        req = '0; req_transmit = '0; req_dc = '0; tft_busy = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_checks++;
        if (grant !== 3'b000 || tft_transmit !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: grant=%b tx=%b want 000/0", grant, tft_transmit);
        end
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (grant !== 3'b000 || tft_transmit !== 1'b0 || tft_dc !== 1'b0 || tft_data !== 8'h00 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b tx=%b dc=%b data=%h to=%b want all zero",
                     grant, tft_transmit, tft_dc, tft_data, timeout);
        end
        n_checks++;
        if (req_busy !== 3'b111) begin
            n_fail++; $display("FAIL reset_busy: req_busy=%b want 111", req_busy);
        end
        model_last = 2;
    endtask

    task automatic test_single_stream();
        int z;
        req = 3'b001;
        wait_grant("single_grant", z);
        n_checks++;
        if (grant !== 3'b001 || z != 1) begin
            n_fail++; $display("FAIL single_grant: grant=%b latency=%0d want 001/1", grant, z);
        end
        req_transmit = 3'b001; req_dc = 3'b000; req_data[7:0] = CASET;
        #1;
        n_checks++;
        if (tft_transmit !== 1'b1 || tft_dc !== 1'b0 || tft_data !== 8'h2A) begin
            n_fail++; $display("FAIL byte_cmd: tx=%b dc=%b data=%h want 1/0/2a", tft_transmit, tft_dc, tft_data);
        end
        cyc();
        req_dc = 3'b001; req_data[7:0] = 8'h10;
        #1;
        n_checks++;
        if (tft_transmit !== 1'b1 || tft_dc !== 1'b1 || tft_data !== 8'h10) begin
            n_fail++; $display("FAIL byte_data: tx=%b dc=%b data=%h want 1/1/10", tft_transmit, tft_dc, tft_data);
        end
        cyc();
        req_transmit = '0; tft_busy = 1'b1;
        #1;
        n_checks++;
        if (req_busy !== 3'b111) begin
            n_fail++; $display("FAIL busy_owner_hi: req_busy=%b want 111", req_busy);
        end
        tft_busy = 1'b0;
        #1;
        n_checks++;
        if (req_busy !== 3'b110) begin
            n_fail++; $display("FAIL busy_owner_lo: req_busy=%b want 110", req_busy);
        end
        req = '0;
        cyc();
        n_checks++;
        if (grant !== 3'b000) begin
            n_fail++; $display("FAIL single_release: grant=%b want 000", grant);
        end
        model_last = 0;
        idle_all();
    endtask

    task automatic test_round_robin();
        int z;
        logic [2:0] exp;
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            exp = 3'b001 << rr_next(req, model_last);
            wait_grant("rr_wait", z);
            n_checks++;
            if (grant !== exp || z != (n == 0 ? 1 : 2)) begin
                n_fail++; $display("FAIL rr_grant%0d: grant=%b gap=%0d want %b gap=%0d",
                                   n, grant, z, exp, (n == 0 ? 1 : 2));
            end
            req_transmit = exp; req_data = {3{8'h55}};
            cyc();
            req_transmit = '0;
            req = req & ~exp;
            cyc();
            n_checks++;
            if (grant !== 3'b000) begin
                n_fail++; $display("FAIL rr_release%0d: grant=%b want 000", n, grant);
            end
            for (int i = 0; i < 3; i++) if (exp[i]) model_last = i;
            req = (n == 3) ? 3'b000 : 3'b111;
        end
        idle_all();
    endtask

    task automatic test_ignore_other();
        int z;
        logic [2:0] exp;
        req = 3'b010;
        exp = 3'b001 << rr_next(req, model_last);
        wait_grant("ign_wait", z);
        n_checks++;
        if (grant !== exp) begin
            n_fail++; $display("FAIL ign_grant: grant=%b want %b", grant, exp);
        end
        req_transmit = 3'b001; req_dc = 3'b001; req_data = {8'h00, 8'h5C, 8'hFF};
        tft_busy = 1'b0;
        #1;
        n_checks++;
        if (tft_transmit !== 1'b0 || req_busy[0] !== 1'b1 || req_busy[1] !== 1'b0 || tft_data !== 8'h5C) begin
            n_fail++; $display("FAIL ign_strobe: tx=%b busy=%b data=%h want 0/x01/5c",
                               tft_transmit, req_busy, tft_data);
        end
        req_transmit = '0; req = '0;
        cyc();
        model_last = 1;
        idle_all();
    endtask

    task automatic test_drain_busy();
        int z;
        logic [2:0] exp;
        req = 3'b001;
        wait_grant("drain_wait", z);
        n_checks++;
        if (grant !== 3'b001) begin
            n_fail++; $display("FAIL drain_grant: grant=%b want 001", grant);
        end
        tft_busy = 1'b1;
        req = 3'b110;
        model_last = 0;
        exp = 3'b001 << rr_next(req, model_last);
        cyc();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (grant !== 3'b000) begin
                n_fail++; $display("FAIL drain_hold%0d: grant=%b want 000", i, grant);
            end
            cyc();
        end
        tft_busy = 1'b0;
        cyc();
        n_checks++;
        if (grant !== 3'b000) begin
            n_fail++; $display("FAIL drain_early: grant=%b want 000", grant);
        end
        cyc();
        n_checks++;
        if (grant !== exp) begin
            n_fail++; $display("FAIL drain_next: grant=%b want %b", grant, exp);
        end
        req = '0;
        cyc();
        for (int i = 0; i < 3; i++) if (exp[i]) model_last = i;
        idle_all();
    endtask

    task automatic test_random();
        int z, w;
        logic [2:0] r, t, dc, exp_busy;
        logic [23:0] d;
        logic b;
        for (int it = 0; it < 25; it++) begin
            r = 3'($urandom_range(1, 7));
            req = r;
            w = rr_next(r, model_last);
            wait_grant("rand_wait", z);
            n_checks++;
            if (grant !== (3'b001 << w) || z != 1) begin
                n_fail++; $display("FAIL rand_grant%0d: req=%b grant=%b lat=%0d want %b/1",
                                   it, r, grant, z, 3'b001 << w);
            end
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                t = 3'($urandom); dc = 3'($urandom); d = 24'($urandom); b = 1'($urandom);
                req_transmit = t; req_dc = dc; req_data = d; tft_busy = b;
                exp_busy = (3'b111 & ~(3'b001 << w)) | (3'(b) << w);
                #1;
                n_checks++;
                if (tft_transmit !== t[w] || tft_dc !== dc[w] || tft_data !== d[8*w +: 8] || req_busy !== exp_busy) begin
                    n_fail++; $display("FAIL rand_pass%0d: tx=%b dc=%b data=%h busy=%b want %b/%b/%h/%b",
                                       it, tft_transmit, tft_dc, tft_data, req_busy,
                                       t[w], dc[w], d[8*w +: 8], exp_busy);
                end
                cyc();
            end
            req_transmit = '0; tft_busy = 1'b0; req = '0;
            cyc();
            model_last = w;
            repeat (2) cyc();
        end
        idle_all();
    endtask

    task automatic test_timeout();
        int z;
        req = 3'b001;
        wait_grant("to_wait", z);
        n_checks++;
        if (grant !== 3'b001) begin
            n_fail++; $display("FAIL to_grant: grant=%b want 001", grant);
        end
`ifdef TFT_ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            cyc();
            n_checks++;
            if (timeout !== (i == 8) || grant !== ((i < 8) ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL to_cycle%0d: timeout=%b grant=%b want %b/%b",
                                   i, timeout, grant, (i == 8), ((i < 8) ? 3'b001 : 3'b000));
            end
        end
        cyc();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse_width: timeout=%b want 0", timeout);
        end
        model_last = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_checks++;
            if (grant !== 3'b000) begin
                n_fail++; $display("FAIL to_masked%0d: grant=%b want 000", i, grant);
            end
        end
        req = 3'b000;
        cyc();
        req = 3'b001;
        wait_grant("to_regrant", z);
        n_checks++;
        if (grant !== 3'b001 || z != 1) begin
            n_fail++; $display("FAIL to_regrant: grant=%b lat=%0d want 001/1", grant, z);
        end
`else
        for (int i = 1; i <= 20; i++) begin
            cyc();
            n_checks++;
            if (timeout !== 1'b0 || grant !== 3'b001) begin
                n_fail++; $display("FAIL no_wd%0d: timeout=%b grant=%b want 0/001", i, timeout, grant);
            end
        end
`endif
        req = '0;
        cyc();
        model_last = 0;
        idle_all();
    endtask

    task automatic test_reset_mid();
        int z;
        req = 3'b001;
        wait_grant("rst_wait", z);
        req_transmit = 3'b001;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 3'b000 || tft_transmit !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: grant=%b tx=%b to=%b want 000/0/0", grant, tft_transmit, timeout);
        end
        cyc();
        req_transmit = '0;
        rst_n = 1'b1;
        model_last = 2;
        req = 3'b111;
        wait_grant("rst_after", z);
        n_checks++;
        if (grant !== (3'b001 << rr_next(3'b111, model_last))) begin
            n_fail++; $display("FAIL rst_first: grant=%b want 001", grant);
        end
        req = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_ignore_other();
        test_drain_busy();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
